// File: rtl/ddr_write_coalescer_if.sv
// Pixel-in / DDR-write-out bundle for the write coalescer.
// The slave modport is the coalescer itself; master is the rasteriser/FIFO side.
interface ddr_write_coalescer_if #(
  parameter int PIXEL_WIDTH = 16,
  parameter int ADDR_WIDTH  = 27
);
  logic                     pixel_valid_in;
  logic                     pixel_ready_out;
  logic [ADDR_WIDTH+2:0]    pixel_addr_in;
  logic [PIXEL_WIDTH-1:0]   pixel_data_in;
  logic                     frame_flush_in;
  logic [8*PIXEL_WIDTH+15:0] write_data;
  logic                     last_write;
  logic                     data_fifo_valid_in;
  logic                     data_fifo_ready_out;
  logic [ADDR_WIDTH-1:0]    write_addr;
  logic                     addr_fifo_valid_in;
  logic                     addr_fifo_ready_out;
  logic                     busy_out;
  logic [31:0]              lines_written_out;

  modport slave (
    input  pixel_valid_in, pixel_addr_in, pixel_data_in, frame_flush_in,
    input  data_fifo_ready_out, addr_fifo_ready_out,
    output pixel_ready_out, write_data, last_write, data_fifo_valid_in,
    output write_addr, addr_fifo_valid_in, busy_out, lines_written_out
  );

  modport master (
    output pixel_valid_in, pixel_addr_in, pixel_data_in, frame_flush_in,
    output data_fifo_ready_out, addr_fifo_ready_out,
    input  pixel_ready_out, write_data, last_write, data_fifo_valid_in,
    input  write_addr, addr_fifo_valid_in, busy_out, lines_written_out
  );
endinterface

// File: rtl/ddr_write_coalescer.sv
// Gathers scattered 16-bit pixel writes into 128-bit DDR words with byte strobes and
// emits each finished line as a single-beat write into the data and address FIFOs.
module ddr_write_coalescer #(
  parameter int PIXEL_WIDTH   = 16,
  parameter int ADDR_WIDTH    = 27,
  parameter int FLUSH_TIMEOUT = 64
) (
  input logic                   clk_in,
  input logic                   rst_n_in,
  ddr_write_coalescer_if.slave  bus
);
  localparam int LINE_W = 8 * PIXEL_WIDTH;
  localparam int CNT_W  = $clog2(FLUSH_TIMEOUT + 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FLUSH} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cur_word;
  logic [LINE_W-1:0]       line_data;
  logic [15:0]             line_strb;
  logic [CNT_W-1:0]        idle_cnt;
  logic [31:0]             lines;
  logic                    data_valid;
  logic                    addr_valid;
  logic [LINE_W+15:0]      wr_data;
  logic [ADDR_WIDTH-1:0]   wr_addr;

  logic [ADDR_WIDTH-1:0]   pix_word;
  logic [2:0]              pix_slot;
  logic                    word_differs;
  logic                    ready;
  logic                    accept;
  logic                    timeout_hit;
  logic                    flush_now;
  logic [ADDR_WIDTH-1:0]   flush_word;
  logic                    data_left;
  logic                    addr_left;
  logic [LINE_W-1:0]       next_data;
  logic [15:0]             next_strb;

  assign pix_word     = bus.pixel_addr_in[ADDR_WIDTH+2:3];
  assign pix_slot     = bus.pixel_addr_in[2:0];
  assign word_differs = bus.pixel_valid_in && (pix_word != cur_word);
  assign ready        = (state == EMPTY) || ((state == FILLING) && !word_differs);
  assign accept       = bus.pixel_valid_in && ready;
  assign timeout_hit  = !accept && ((int'(idle_cnt) + 1) >= FLUSH_TIMEOUT);
  assign flush_word   = (state == EMPTY) ? pix_word : cur_word;
  assign data_left    = data_valid && !bus.data_fifo_ready_out;
  assign addr_left    = addr_valid && !bus.addr_fifo_ready_out;

  // Line contents as they will be after this cycle's accepted pixel (last write to a slot wins).
  always_comb begin
    next_data = line_data;
    next_strb = line_strb;
    if (accept) begin
      next_data[int'(pix_slot) * PIXEL_WIDTH +: PIXEL_WIDTH] = bus.pixel_data_in;
      next_strb[int'(pix_slot) * 2 +: 2]                     = 2'b11;
    end
  end

  always_comb begin
    flush_now = 1'b0;
    case (state)
      EMPTY:   flush_now = accept && bus.frame_flush_in;
      FILLING: flush_now = (next_strb == 16'hFFFF) || word_differs ||
                           bus.frame_flush_in || timeout_hit;
      default: flush_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= EMPTY;
      cur_word   <= '0;
      line_data  <= '0;
      line_strb  <= '0;
      idle_cnt   <= '0;
      lines      <= '0;
      data_valid <= 1'b0;
      addr_valid <= 1'b0;
      wr_data    <= '0;
      wr_addr    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            cur_word  <= pix_word;
            line_data <= next_data;
            line_strb <= next_strb;
            idle_cnt  <= '0;
            state     <= flush_now ? FLUSH : FILLING;
          end
        end
        FILLING: begin
          line_data <= next_data;
          line_strb <= next_strb;
          idle_cnt  <= accept ? '0 : idle_cnt + 1'b1;
          if (flush_now) state <= FLUSH;
        end
        FLUSH: begin
          // Each FIFO side retires on its own handshake; the line is done when both have.
          if (data_valid && bus.data_fifo_ready_out) data_valid <= 1'b0;
          if (addr_valid && bus.addr_fifo_ready_out) addr_valid <= 1'b0;
          if (!data_left && !addr_left) begin
            lines     <= lines + 32'd1;
            line_data <= '0;
            line_strb <= '0;
            idle_cnt  <= '0;
            state     <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase

      if (flush_now) begin
        data_valid <= 1'b1;
        addr_valid <= 1'b1;
        wr_data    <= {next_data, next_strb};
        wr_addr    <= flush_word;
      end
    end
  end

  assign bus.pixel_ready_out    = ready;
  assign bus.write_data         = wr_data;
  assign bus.last_write         = 1'b1;
  assign bus.data_fifo_valid_in = data_valid;
  assign bus.write_addr         = wr_addr;
  assign bus.addr_fifo_valid_in = addr_valid;
  assign bus.busy_out           = (state != EMPTY);
  assign bus.lines_written_out  = lines;
endmodule
